led_scan_driver: RTL
====================

# led_scan_driver

Time-multiplexed driver for a bank of common-cathode 7-segment digits. It latches a packed hex value, decimal-point mask and blank mask from the core. It scans one digit at a time with a parametrised slot length and PWM brightness, and produces a registered segment bus plus a one-hot digit select. Updates are tear-free: new data becomes visible only at a frame boundary. The block sits between the core's I/O register file and the board's shared segment/digit pins.

## Interface
- `DIGIT_NUM`, 8: number of digits scanned; must be 2 or more.
- `SCAN_DIV_LOG2`, 10: log2 of clock cycles per digit slot; must be greater than `BRIGHT_WIDTH`.
- `BRIGHT_WIDTH`, 3: brightness code width.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `valueIn`  in  4*DIGIT_NUM  hex nibbles; digit i is `[4i+3:4i]`.
- `dpIn`  in  DIGIT_NUM  decimal point per digit.
- `blankIn`  in  DIGIT_NUM  1 = digit dark.
- `load`  in  1  single-cycle strobe; captures `valueIn`, `dpIn` and `blankIn` into the pending register.
- `brightness`  in  BRIGHT_WIDTH  duty code, sampled every cycle.
- `segOut`  out  8  bits [6:0] = segments a..g, bit 7 = dp; 1 = lit.
- `digitSel`  out  DIGIT_NUM  one-hot active-high digit enable, or all zero.
- `frameDone`  out  1  one-cycle pulse when digit DIGIT_NUM-1 finishes its slot.

## Operation
- Prescaler `presc` (SCAN_DIV_LOG2 bits) increments every cycle and wraps to 0.
- Digit index `idx` advances when `presc` is all ones. It wraps from DIGIT_NUM-1 to 0, and that wrap is the frame boundary.
- Pending register and `pendValid` flag:
  - `load` writes the pending register and sets `pendValid`.
  - A second `load` before commit overwrites the pending register (last wins).
- Commit happens on the frame-boundary cycle when `pendValid` is set:
  - the pending register is copied to the display register and `pendValid` is cleared;
  - commit uses the pending contents present before that edge;
  - a `load` on the boundary cycle is kept pending for the next frame, and `pendValid` stays set.
- Decode uses the nibble of digit `idx` from the display register:
  - 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07;
  - 8→0x7F, 9→0x6F, A→0x77, b→0x7C, c→0x58, d→0x5E, E→0x79, F→0x71.
  - Bit 7 is OR'd with the dp bit.
- Slot phase `ph = presc[SCAN_DIV_LOG2-1 -: BRIGHT_WIDTH]`.
- The digit is lit only when all three hold:
  - `ph <= brightness`;
  - `presc != 0`, a one-cycle anti-ghost gap at every slot start;
  - the digit's display blank bit is 0.
- When the digit is lit, `digitSel = 1 << idx` and `segOut` = decoded pattern. Otherwise both are 0.
- Brightness all ones gives full duty minus the gap cycle. Brightness 0 gives a 1/2^BRIGHT_WIDTH duty.

## Timing
- `segOut`, `digitSel` and `frameDone` are registered. They reflect the `presc`/`idx` state of the previous cycle (1-cycle latency).
- Slot length is 2^SCAN_DIV_LOG2 cycles. A frame is DIGIT_NUM slots.
- From `load` to first visible change: at most one frame plus 2 cycles.
- `frameDone` is high for exactly one cycle, the cycle after the `presc`-wrap on `idx` = DIGIT_NUM-1.
- Reset values:
  - `presc` = 0, `idx` = 0, `pendValid` = 0;
  - display value 0, dp 0, blank all ones (dark until first commit);
  - `segOut` = 0, `digitSel` = 0, `frameDone` = 0.
- Reset asserted mid-frame: all state returns to reset values immediately, asynchronously. A pending load is discarded.
- Brightness changes take effect on the next cycle; no glitch protection is required.

## Structure
- Shared package `Types` holds:
  - `SEG_WIDTH` = 8 and `HEX_WIDTH` = 4;
  - `SegPath` typedef (logic [7:0]);
  - the 16 segment pattern constants;
  - the `SEG_DP` bit index (7).
- Sub-module `seg_decoder` is purely combinational: HEX_WIDTH + dp in, SegPath out. One instance decodes the selected digit. Only one decoder is used, not one per digit.
- Top level holds the prescaler, index counter, pending/display registers, PWM compare and output registers.

## Test plan
All scenarios use DIGIT_NUM=4, SCAN_DIV_LOG2=4, BRIGHT_WIDTH=2.

1. Release reset without `load`: for 2 frames, `digitSel`=0 and `segOut`=0; `frameDone` pulses every 64 cycles.
2. `load` valueIn=0x8A10, dp=4'b0001, blank=0, brightness=3:
   - after commit, slot 0 shows `segOut`=0xBF (0x3F with dp bit 7 set) with `digitSel`=0001 for cycles 1..15 of the slot;
   - slots 1..3 show 0x06, 0x77 and 0x7F;
   - `digitSel` is 0 on each slot's first cycle.
3. brightness=0: each digit lit for exactly 3 cycles per 16-cycle slot (`presc`=1..3). brightness=1: lit for 7 cycles.
4. `load` A, then `load` B mid-frame, then `load` C on the boundary cycle:
   - B is displayed in the next frame;
   - C is displayed one frame later;
   - A is never displayed.
5. blank=4'b0100: digit 2 stays dark (`digitSel[2]` never 1) while the other digits scan normally.
6. Assert `rst` mid-slot with `pendValid` set: outputs go to 0 asynchronously. After release, the display stays dark, confirming the pending load was discarded.

Source files
------------

// File: rtl/led_scan_driver_pkg.sv
// Shared types and segment patterns for the LED scan driver.
//   SEG_WIDTH / HEX_WIDTH : segment bus width and digit nibble width
//   SegPath               : segment bus payload, bits [6:0] = a..g, bit 7 = dp
//   SEG_0 .. SEG_F        : active-high segment patterns per hex digit
package Types;

    localparam int unsigned SEG_WIDTH = 8;
    localparam int unsigned HEX_WIDTH = 4;
    localparam int unsigned SEG_DP    = 7;

    typedef logic [SEG_WIDTH-1:0] SegPath;

    localparam SegPath SEG_0 = 8'h3F;
    localparam SegPath SEG_1 = 8'h06;
    localparam SegPath SEG_2 = 8'h5B;
    localparam SegPath SEG_3 = 8'h4F;
    localparam SegPath SEG_4 = 8'h66;
    localparam SegPath SEG_5 = 8'h6D;
    localparam SegPath SEG_6 = 8'h7D;
    localparam SegPath SEG_7 = 8'h07;
    localparam SegPath SEG_8 = 8'h7F;
    localparam SegPath SEG_9 = 8'h6F;
    localparam SegPath SEG_A = 8'h77;
    localparam SegPath SEG_B = 8'h7C;
    localparam SegPath SEG_C = 8'h58;
    localparam SegPath SEG_D = 8'h5E;
    localparam SegPath SEG_E = 8'h79;
    localparam SegPath SEG_F = 8'h71;

endpackage

// File: rtl/led_scan_driver_seg.sv
// Hex nibble to 7-segment pattern decoder (combinational).
//   hex   : nibble to display
//   dp    : decimal point, OR'd into bit SEG_DP
//   seg_c : segment pattern, 1 = lit
module seg_decoder
    import Types::*;
(
    input  logic [HEX_WIDTH-1:0] hex,
    input  logic                 dp,
    output SegPath               seg_c
);

    always_comb begin
        seg_c = '0;
        case (hex)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
            4'hA: seg_c = SEG_A;
            4'hB: seg_c = SEG_B;
            4'hC: seg_c = SEG_C;
            4'hD: seg_c = SEG_D;
            4'hE: seg_c = SEG_E;
            4'hF: seg_c = SEG_F;
            default: seg_c = '0;
        endcase
        seg_c[SEG_DP] = seg_c[SEG_DP] | dp;
    end

endmodule

// File: rtl/led_scan_driver.sv
// Time-multiplexed common-cathode 7-segment scan driver.
// Data loaded from the core is held pending and committed to the display
// register only at a frame boundary, so a frame never mixes old and new digits.
//   clk, rst          : clock, asynchronous active-low reset
//   valueIn           : packed hex nibbles, digit i at [4i+3:4i]
//   dpIn, blankIn     : per-digit decimal point / blank (1 = dark)
//   load              : single-cycle capture strobe into the pending register
//   brightness        : PWM duty code, sampled every cycle
//   segOut, digitSel  : registered segment bus and one-hot digit enable
//   frameDone         : one-cycle pulse after the last digit's slot ends
module led_scan_driver
    import Types::*;
#(
    parameter int unsigned DIGIT_NUM     = 8,
    parameter int unsigned SCAN_DIV_LOG2 = 10,
    parameter int unsigned BRIGHT_WIDTH  = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [HEX_WIDTH*DIGIT_NUM-1:0] valueIn,
    input  logic [DIGIT_NUM-1:0]           dpIn,
    input  logic [DIGIT_NUM-1:0]           blankIn,
    input  logic                           load,
    input  logic [BRIGHT_WIDTH-1:0]        brightness,
    output SegPath                         segOut,
    output logic [DIGIT_NUM-1:0]           digitSel,
    output logic                           frameDone
);

    localparam int unsigned IDX_WIDTH   = $clog2(DIGIT_NUM);
    localparam int unsigned VALUE_WIDTH = HEX_WIDTH * DIGIT_NUM;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DIGIT_NUM - 1);

    logic [SCAN_DIV_LOG2-1:0] presc;
    logic [IDX_WIDTH-1:0]     idx;

    logic [VALUE_WIDTH-1:0]   pendValue;
    logic [DIGIT_NUM-1:0]     pendDp;
    logic [DIGIT_NUM-1:0]     pendBlank;
    logic                     pendValid;

    logic [VALUE_WIDTH-1:0]   dispValue;
    logic [DIGIT_NUM-1:0]     dispDp;
    logic [DIGIT_NUM-1:0]     dispBlank;

    logic                     slotEnd_c;
    logic                     frameEnd_c;
    logic                     commit_c;
    logic [BRIGHT_WIDTH-1:0]  ph_c;
    logic                     lit_c;
    logic [HEX_WIDTH-1:0]     nibble_c;
    logic                     dp_c;
    SegPath                   seg_c;
    SegPath                   segNext_c;
    logic [DIGIT_NUM-1:0]     digitSelNext_c;

    // Slot/frame boundary detection and PWM gating.
    always_comb begin
        slotEnd_c      = &presc;
        frameEnd_c     = slotEnd_c && (idx == LAST_IDX);
        commit_c       = frameEnd_c && pendValid;
        ph_c           = presc[SCAN_DIV_LOG2-1 -: BRIGHT_WIDTH];
        nibble_c       = dispValue[HEX_WIDTH*idx +: HEX_WIDTH];
        dp_c           = dispDp[idx];
        // presc == 0 leaves a dark cycle at each slot start to avoid ghosting.
        lit_c          = (ph_c <= brightness) && (presc != '0) && !dispBlank[idx];
        segNext_c      = '0;
        digitSelNext_c = '0;
        if (lit_c) begin
            segNext_c      = seg_c;
            digitSelNext_c = DIGIT_NUM'(1) << idx;
        end
    end

    seg_decoder uDecoder (
        .hex   (nibble_c),
        .dp    (dp_c),
        .seg_c (seg_c)
    );

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc + SCAN_DIV_LOG2'(1);
            if (slotEnd_c) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_WIDTH'(1);
            end
        end
    end

    // Pending register; a load on the commit cycle stays pending for the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pendValue <= '0;
            pendDp    <= '0;
            pendBlank <= '0;
            pendValid <= 1'b0;
        end else begin
            if (load) begin
                pendValue <= valueIn;
                pendDp    <= dpIn;
                pendBlank <= blankIn;
            end
            pendValid <= load || (pendValid && !frameEnd_c);
        end
    end

    // Display register, dark until the first commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dispValue <= '0;
            dispDp    <= '0;
            dispBlank <= '1;
        end else if (commit_c) begin
            dispValue <= pendValue;
            dispDp    <= pendDp;
            dispBlank <= pendBlank;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            segOut    <= '0;
            digitSel  <= '0;
            frameDone <= 1'b0;
        end else begin
            segOut    <= segNext_c;
            digitSel  <= digitSelNext_c;
            frameDone <= frameEnd_c;
        end
    end

endmodule
